stack_engine: RTL and testbench

- Memory-stage responder for the stack requests issued by the decode-stage control FSM: PUSH/POP of flags (16-bit) and PC (32-bit) for interrupts, CALL/RET and PUSH/POP instructions.
- Owns the stack pointer and occupancy count.
- Splits 32-bit operands into two 16-bit data-memory accesses, sequences synchronous-RAM reads, and returns one response per accepted request.

---
 rtl/stack_pkg.sv | 27 ++
 rtl/stack_pointer.sv | 34 +++
 rtl/stack_engine.sv | 110 +++++++++++
 tb/tb_stack_engine.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: stack request opcodes, engine states and operand-size helpers shared with decode.
package stack_pkg;
    typedef enum logic [1:0] {
        PUSH16 = 2'b00,
        PUSH32 = 2'b01,
        POP16  = 2'b10,
        POP32  = 2'b11
    } stack_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        RD_LO,
        RD_HI,
        CAP,
        RESP
    } stack_state_e;

    function automatic logic [1:0] op_words(stack_op_e op);
        return op[0] ? 2'd2 : 2'd1;
    endfunction

    function automatic logic op_is_pop(stack_op_e op);
        return op[1];
    endfunction
endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: occupancy counter deriving the downward-growing stack pointer and
// overflow/underflow for an n-word request.
module stack_pointer #(
    parameter int ADDR_W   = 11,
    parameter int SP_RESET = 2**ADDR_W-1,
    parameter int DEPTH    = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    input  logic [1:0]        n,
    output logic [ADDR_W-1:0] sp,
    output logic              overflow,
    output logic              underflow
);
    localparam int CW = ADDR_W + 2;

    logic [ADDR_W:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc)
            count <= count + (ADDR_W+1)'(1);
        else if (dec)
            count <= count - (ADDR_W+1)'(1);
    end

    // Dropping the count MSB is safe: a full stack wraps to the same modular address.
    assign sp        = ADDR_W'(SP_RESET) - count[ADDR_W-1:0];
    assign overflow  = ({1'b0, count} + CW'(n)) > CW'(DEPTH);
    assign underflow = count < (ADDR_W+1)'(n);
endmodule

// File: rtl/stack_engine.sv
// stack_engine: memory-stage stack responder; splits 16/32-bit push/pop requests into
// 16-bit synchronous-RAM accesses and returns one response per accepted request.
module stack_engine
    import stack_pkg::*;
#(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 16,
    parameter int SP_RESET = 2**ADDR_W-1,
    parameter int DEPTH    = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   sp,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    stack_state_e        state;
    stack_op_e           op;
    stack_op_e           req_op_e;
    logic [2*DATA_W-1:0] wdata;
    logic [2*DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0]   lo;
    logic                err;
    logic                accept;
    logic                bad;
    logic                overflow;
    logic                underflow;

    assign req_op_e  = stack_op_e'(req_op);
    assign req_ready = state == IDLE;
    assign accept    = req_valid && req_ready;
    assign bad       = op_is_pop(req_op_e) ? underflow : overflow;

    stack_pointer #(
        .ADDR_W  (ADDR_W),
        .SP_RESET(SP_RESET),
        .DEPTH   (DEPTH)
    ) u_sp (
        .clk      (clk),
        .reset    (reset),
        .inc      (mem_we),
        .dec      (state == RD_LO || state == RD_HI),
        .n        (op_words(req_op_e)),
        .sp       (sp),
        .overflow (overflow),
        .underflow(underflow)
    );

    // Push writes at sp then decrements; pop increments then reads, hence sp+1.
    assign mem_we    = state == WR_HI || state == WR_LO;
    assign mem_en    = mem_we || state == RD_LO || state == RD_HI;
    assign mem_addr  = mem_we ? sp : sp + ADDR_W'(1);
    assign mem_wdata = state == WR_HI ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
    assign rsp_valid = state == RESP;
    assign rsp_err   = rsp_valid && err;
    assign rsp_rdata = rdata_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            op      <= PUSH16;
            wdata   <= '0;
            lo      <= '0;
            err     <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= req_op_e;
                    wdata <= req_wdata;
                    err   <= bad;
                    if (bad) begin
                        rdata_r <= '0;
                        state   <= RESP;
                    end else begin
                        state <= req_op_e == PUSH32 ? WR_HI :
                                 req_op_e == PUSH16 ? WR_LO : RD_LO;
                    end
                end
                WR_HI: state <= WR_LO;
                WR_LO: begin
                    rdata_r <= '0;
                    state   <= RESP;
                end
                RD_LO: state <= op == POP32 ? RD_HI : CAP;
                RD_HI: begin
                    lo    <= mem_rdata;
                    state <= CAP;
                end
                // Read data lags its strobe by one cycle, so the final word lands here.
                CAP: begin
                    rdata_r <= op == POP32 ? {mem_rdata, lo} : {{DATA_W{1'b0}}, mem_rdata};
                    state   <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: randomized scoreboard bench; two engines (full depth and DEPTH=4)
// checked against a queue-based stack model and a memory-access script.
module tb_stack_engine;
    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic [10:0] sp;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [10:0] a;
        logic [15:0] d;
        int          cyc;
    } mop_t;

    logic clk = 0;
    logic reset = 1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s", nm);
    endtask

    for (genvar d = 0; d < 2; d++) begin : g
        localparam int DEP = d ? 4 : 2048;
        logic        req_valid = 0;
        logic        req_ready;
        logic [1:0]  req_op = 0;
        logic [31:0] req_wdata = 0;
        logic        rsp_valid;
        logic        rsp_err;
        logic [31:0] rsp_rdata;
        logic [10:0] sp;
        logic        mem_en;
        logic        mem_we;
        logic [10:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] mem_rdata = 0;
        logic [15:0] mem [2048];
        logic [15:0] stk[$];
        rsp_t        rq[$];
        mop_t        mq[$];

        stack_engine #(.DEPTH(DEP)) dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid),
            .req_ready(req_ready),
            .req_op   (req_op),
            .req_wdata(req_wdata),
            .rsp_valid(rsp_valid),
            .rsp_err  (rsp_err),
            .rsp_rdata(rsp_rdata),
            .sp       (sp),
            .mem_en   (mem_en),
            .mem_we   (mem_we),
            .mem_addr (mem_addr),
            .mem_wdata(mem_wdata),
            .mem_rdata(mem_rdata)
        );

        always @(posedge clk) begin
            if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        end

        task automatic issue(input logic [1:0] op, input logic [31:0] wd);
            logic [10:0] s;
            logic [15:0] lo, hi;
            rsp_t r;
            int c, n, lat;
            bit ok;
            req_valid = 1;
            req_op = op;
            req_wdata = wd;
            ok = 0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = req_ready;
            end
            if (!ok) begin
                fail_now($sformatf("accept_timeout_%0d", d));
                req_valid = 0;
                return;
            end
            c = cyc;
            s = 11'h7FF - 11'(stk.size());
            n = op[0] ? 2 : 1;
            r.err = op[1] ? (stk.size() < n) : (stk.size() + n > DEP);
            r.rd = 0;
            lat = 1;
            if (!r.err) begin
                case (op)
                    2'b00: begin
                        mq.push_back('{1'b1, s, wd[15:0], c + 1});
                        stk.push_back(wd[15:0]);
                        lat = 2;
                    end
                    2'b01: begin
                        mq.push_back('{1'b1, s, wd[31:16], c + 1});
                        mq.push_back('{1'b1, 11'(s - 11'd1), wd[15:0], c + 2});
                        stk.push_back(wd[31:16]);
                        stk.push_back(wd[15:0]);
                        lat = 3;
                    end
                    2'b10: begin
                        mq.push_back('{1'b0, 11'(s + 11'd1), 16'h0, c + 1});
                        r.rd = {16'h0, stk.pop_back()};
                        lat = 3;
                    end
                    default: begin
                        mq.push_back('{1'b0, 11'(s + 11'd1), 16'h0, c + 1});
                        mq.push_back('{1'b0, 11'(s + 11'd2), 16'h0, c + 2});
                        lo = stk.pop_back();
                        hi = stk.pop_back();
                        r.rd = {hi, lo};
                        lat = 4;
                    end
                endcase
            end
            r.sp = 11'h7FF - 11'(stk.size());
            r.cyc = c + lat;
            rq.push_back(r);
            @(posedge clk);
            #1;
            req_valid = 0;
            req_wdata = $urandom;
        endtask

        always @(negedge clk) begin : mon
            rsp_t r;
            mop_t m;
            if (!reset) begin
                if (rsp_valid) begin
                    if (rq.size() == 0) fail_now($sformatf("unexpected_rsp_%0d", d));
                    else begin
                        r = rq.pop_front();
                        chk($sformatf("rsp_err_%0d", d), 64'(rsp_err), 64'(r.err));
                        chk($sformatf("rsp_rdata_%0d", d), 64'(rsp_rdata), 64'(r.rd));
                        chk($sformatf("rsp_sp_%0d", d), 64'(sp), 64'(r.sp));
                        chk($sformatf("rsp_cycle_%0d", d), 64'(cyc), 64'(r.cyc));
                    end
                end
                if (mem_en) begin
                    if (mq.size() == 0) fail_now($sformatf("unexpected_mem_%0d", d));
                    else begin
                        m = mq.pop_front();
                        chk($sformatf("mem_we_%0d", d), 64'(mem_we), 64'(m.we));
                        chk($sformatf("mem_addr_%0d", d), 64'(mem_addr), 64'(m.a));
                        chk($sformatf("mem_cycle_%0d", d), 64'(cyc), 64'(m.cyc));
                        if (m.we) chk($sformatf("mem_wdata_%0d", d), 64'(mem_wdata), 64'(m.d));
                    end
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 100 && (g[0].rq.size() + g[1].rq.size() + g[0].mq.size() + g[1].mq.size()) != 0; i++)
            @(posedge clk);
        #1;
        chk("drain", 64'(g[0].rq.size() + g[1].rq.size() + g[0].mq.size() + g[1].mq.size()), 64'd0);
    endtask

    task automatic flush();
        g[0].rq.delete(); g[0].mq.delete(); g[0].stk.delete();
        g[1].rq.delete(); g[1].mq.delete(); g[1].stk.delete();
    endtask

    initial begin
        #500000;
        fail_now("watchdog");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        g[0].req_valid = 1;
        g[0].req_op = 2'b01;
        repeat (3) begin
            @(negedge clk);
            chk("rst_sp", 64'(g[0].sp), 64'h7FF);
            chk("rst_ready", 64'(g[0].req_ready), 64'd1);
            chk("rst_rsp_valid", 64'(g[0].rsp_valid), 64'd0);
            chk("rst_mem_en", 64'(g[0].mem_en), 64'd0);
        end
        g[0].req_valid = 0;
        reset = 0;
        @(posedge clk);
        #1;
        g[0].issue(2'b01, 32'hDEADBEEF);
        drain();
        chk("push32_sp", 64'(g[0].sp), 64'h7FD);
        g[0].issue(2'b11, $urandom);
        drain();
        chk("pop32_data", 64'(g[0].rsp_rdata), 64'hDEADBEEF);
        chk("pop32_sp", 64'(g[0].sp), 64'h7FF);
        g[0].issue(2'b10, $urandom);
        drain();
        g[0].issue(2'b00, $urandom);
        g[0].issue(2'b11, $urandom);
        drain();
        chk("underflow32_sp", 64'(g[0].sp), 64'h7FE);
        g[1].issue(2'b01, $urandom);
        g[1].issue(2'b00, $urandom);
        g[1].issue(2'b01, $urandom);
        g[1].issue(2'b00, $urandom);
        g[1].issue(2'b00, $urandom);
        drain();
        chk("depth4_sp", 64'(g[1].sp), 64'h7FB);
        repeat (400) begin
            if ($urandom_range(1) == 0) g[0].issue(2'($urandom_range(3)), $urandom);
            else g[1].issue(2'($urandom_range(3)), $urandom);
        end
        drain();
        g[0].issue(2'b01, $urandom);
        @(posedge clk);
        #1;
        chk("wr_lo_strobe", 64'({g[0].mem_en, g[0].mem_we}), 64'b11);
        reset = 1;
        #1;
        chk("abort_mem_en", 64'(g[0].mem_en), 64'd0);
        chk("abort_sp", 64'(g[0].sp), 64'h7FF);
        flush();
        repeat (2) begin
            @(negedge clk);
            chk("abort_rsp_valid", 64'(g[0].rsp_valid), 64'd0);
        end
        reset = 0;
        @(posedge clk);
        #1;
        g[0].issue(2'b10, $urandom);
        drain();
        chk("post_abort_sp", 64'(g[0].sp), 64'h7FF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
